dmem_responder: RTL
===================

# dmem_responder

Data-memory responder serving the load/store requests issued by the CPU's MEM stage. It accepts one request at a time over a req/gnt handshake, performs byte/half/word stores with byte enables, and returns sign- or zero-extended load data with a one-cycle `rvalid_o` pulse after a fixed, parameterised wait. It sits between the MEM stage and the on-chip data RAM and owns the RAM array.

## Interface
- `ADDR_W`, 10: word-address width; the RAM holds 2^ADDR_W 32-bit words.
- `LATENCY`, 2: wait cycles between acceptance and the RAM access; legal range 1..15.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_i`  in  1  request valid.
- `we_i`  in  1  1 = store, 0 = load.
- `addr_i`  in  32  byte address.
- `wdata_i`  in  32  store data, right-aligned.
- `funct3_i`  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `gnt_o`  out  1  request accepted in this cycle when `req_i` is also high.
- `rvalid_o`  out  1  one-cycle response strobe.
- `rdata_o`  out  32  load result; 0 for stores and errors.
- `err_o`  out  1  error flag, valid with `rvalid_o`.
- `busy_o`  out  1  high from acceptance through the response cycle.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: `gnt_o`=1. On `req_i`: latch `we`, `addr`, `wdata` and `funct3`; load the wait counter with LATENCY-1; go to WAIT.
- WAIT: decrement the counter. At the edge where the counter is 0, perform the RAM access and go to RESP.
- RESP: `rvalid_o`=1 with `rdata_o`/`err_o`; return to IDLE on the next edge.
- Word index is `addr[ADDR_W+1:2]`. Higher address bits are ignored, so accesses wrap modulo 4·2^ADDR_W bytes.
- Stores:
  - SB writes lane `addr[1:0]` with `wdata[7:0]`.
  - SH writes lanes {1,0} or {3,2} by `addr[1]` with `wdata[15:0]`.
  - SW writes all four lanes.
  - Unwritten lanes are preserved.
- Loads:
  - Select the byte or half by `addr[1:0]`.
  - LB and LH sign-extend to 32 bits; LBU and LHU zero-extend.
  - LW returns the whole word.
- Illegal `funct3` (011, 110, 111): `err_o`=1, no write, `rdata_o`=0.
- `req_i` outside IDLE is ignored. No queueing; the requester must hold `req_i` until it sees `gnt_o`.
- Reset values: state IDLE, `gnt_o`=0 while `rst`=1, `rvalid_o`=0, `rdata_o`=0, `err_o`=0, `busy_o`=0, counter 0. RAM contents are not cleared.
- Reset mid-operation (WAIT or RESP): abort to IDLE. A store not yet committed is dropped, and no `rvalid_o` is produced.

## Timing
- Acceptance edge E0 = the first edge with `req_i`&`gnt_o`.
- The RAM write commits at edge E(LATENCY).
- `rvalid_o`, `rdata_o` and `err_o` are registered and high for exactly one cycle after E(LATENCY).
- `gnt_o` reasserts one cycle after RESP. Maximum throughput is one access per LATENCY+2 cycles.
- `rdata_o` and `err_o` are held at 0 whenever `rvalid_o`=0.
- `busy_o` = state != IDLE.

## Configuration
- `DMEM_MISALIGN_ERR_EN` defined:
  - A half access with `addr[0]`=1, or a word access with `addr[1:0]`≠0, gives `err_o`=1, no write and `rdata_o`=0.
- Undefined:
  - Low address bits below the access size are forced to 0 (the access is aligned down), and `err_o` stays 0 for misalignment.

## Structure
- Shared package `dmem_pkg`:
  - funct3 codes F3_B/F3_H/F3_W/F3_BU/F3_HU;
  - opcodes OP_I_LOAD=7'b0000011 and OP_S=7'b0100011, shared with the MEM stage;
  - FSM state enum.
- Sub-module `dmem_bank`: the 2^ADDR_W×32 RAM with a 4-bit byte-write-enable and a synchronous read port. Lane steering and extension stay in `dmem_responder`.

## Test plan
- SW 0xDEADBEEF @0x10, then LW @0x10 (LATENCY=2) → `rvalid_o` 3 cycles after each acceptance; LW returns 0xDEADBEEF with `err_o`=0.
- SB 0x80 @0x13 over word 0x11223344 → word becomes 0x80223344. LB @0x13 → 0xFFFFFF80; LBU @0x13 → 0x00000080.
- SH 0x8001 @0x22 → LH @0x22 = 0xFFFF8001 and LHU @0x22 = 0x00008001. Lanes at 0x20/0x21 are unchanged.
- `funct3`=011 store @0x30 → `err_o`=1, `rdata_o`=0; a subsequent LW @0x30 returns the prior contents.
- Misaligned LW @0x41:
  - with `DMEM_MISALIGN_ERR_EN` → `err_o`=1, `rdata_o`=0;
  - without it → returns the word @0x40, `err_o`=0.
- SW 0x12345678 @0x50 with `rst` pulsed during WAIT → no `rvalid_o`, `gnt_o`=1 after reset, and LW @0x50 returns the old value. Also check `req_i` held high back-to-back is granted every LATENCY+2 cycles.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder and the MEM stage:
// funct3 access codes, load/store opcodes and the responder FSM state type.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [6:0] OP_I_LOAD = 7'b0000011;
  localparam logic [6:0] OP_S      = 7'b0100011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/dmem_bank.sv
// Data RAM: 2^ADDR_W x 32 words, per-byte write enables, synchronous read port.
module dmem_bank #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              re,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage load/store responder with fixed LATENCY wait and one-cycle response.
// Define DMEM_MISALIGN_ERR_EN to flag misaligned half/word accesses instead of aligning them down.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [2:0]  funct3_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        busy_o
);

  dmem_state_e       state, state_nxt;
  logic [3:0]        cnt;
  logic              we_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [2:0]        f3_q;
  logic              rvalid_q, err_q;
  logic [31:0]       bank_rdata;

  logic              access, legal, acc_err;
  logic [1:0]        off;
  logic [3:0]        be_lane;
  logic [31:0]       wlane;

  assign access = (state == ST_WAIT) && (cnt == 4'd0);

  // Lane steering; off is the aligned-down byte offset used by both stores and loads
  always_comb begin
    legal   = 1'b1;
    off     = addr_q[1:0];
    be_lane = 4'b0000;
    wlane   = wdata_q;
    case (f3_q)
      F3_B, F3_BU: begin
        be_lane = 4'b0001 << addr_q[1:0];
        wlane   = {4{wdata_q[7:0]}};
      end
      F3_H, F3_HU: begin
        off     = {addr_q[1], 1'b0};
        be_lane = addr_q[1] ? 4'b1100 : 4'b0011;
        wlane   = {2{wdata_q[15:0]}};
      end
      F3_W: begin
        off     = 2'b00;
        be_lane = 4'b1111;
      end
      default: legal = 1'b0;
    endcase
  end

`ifdef DMEM_MISALIGN_ERR_EN
  always_comb begin
    acc_err = !legal;
    if ((f3_q == F3_H || f3_q == F3_HU) && addr_q[0])  acc_err = 1'b1;
    if (f3_q == F3_W && addr_q[1:0] != 2'b00)          acc_err = 1'b1;
  end
`else
  assign acc_err = !legal;
`endif

  dmem_bank #(.ADDR_W(ADDR_W)) u_bank (
    .clk   (clk),
    .re    (access && !we_q && !acc_err && !rst),
    .be    ((access && we_q && !acc_err && !rst) ? be_lane : 4'b0000),
    .addr  (addr_q[ADDR_W+1:2]),
    .wdata (wlane),
    .rdata (bank_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (req_i) state_nxt = ST_WAIT;
      ST_WAIT: if (cnt == 4'd0) state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= 4'd0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      f3_q     <= 3'd0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      if (state == ST_IDLE && req_i) begin
        we_q    <= we_i;
        addr_q  <= addr_i[ADDR_W+1:0];
        wdata_q <= wdata_i;
        f3_q    <= funct3_i;
        cnt     <= 4'(LATENCY - 1);
      end else if (state == ST_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (access) begin
        rvalid_q <= 1'b1;
        err_q    <= acc_err;
      end
    end
  end

  logic [31:0] shifted;
  assign shifted = bank_rdata >> {off, 3'b000};

  always_comb begin
    rdata_o = 32'd0;
    if (rvalid_q && !err_q && !we_q) begin
      case (f3_q)
        F3_B:    rdata_o = {{24{shifted[7]}}, shifted[7:0]};
        F3_BU:   rdata_o = {24'd0, shifted[7:0]};
        F3_H:    rdata_o = {{16{shifted[15]}}, shifted[15:0]};
        F3_HU:   rdata_o = {16'd0, shifted[15:0]};
        default: rdata_o = bank_rdata;
      endcase
    end
  end

  assign gnt_o    = (state == ST_IDLE) && !rst;
  assign busy_o   = (state != ST_IDLE);
  assign rvalid_o = rvalid_q;
  assign err_o    = err_q;

endmodule
